// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: two-stage elastic pipeline that evaluates the branch
// condition, computes target / next PC, flags mispredicts against the
// front-end prediction and keeps saturating branch statistics.
// S1 holds the raw request; S2 holds the resolved result, which drives the
// outputs directly so no input data reaches output data combinationally.
module branch_resolve_unit #(
  parameter int XLEN   = 32,
  parameter int CNT_W  = 16,
  parameter int PC_INC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             cnt_clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [2:0]       br_type,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic             pred_taken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             br_taken,
  output logic             mispredict,
  output logic [XLEN-1:0]  target,
  output logic [XLEN-1:0]  next_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LTU = 3'b010;
  localparam logic [2:0] BR_GEU = 3'b011;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_AL  = 3'b110;
  localparam logic [2:0] BR_NV  = 3'b111;

  localparam logic [XLEN-1:0]  PC_INC_V = XLEN'(PC_INC);
  localparam logic [XLEN-1:0]  XLEN_ZERO = {XLEN{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // stage 1 (request) registers
  logic            s1_valid_r;
  logic [XLEN-1:0] s1_a_r;
  logic [XLEN-1:0] s1_b_r;
  logic [2:0]      s1_type_r;
  logic [XLEN-1:0] s1_pc_r;
  logic [XLEN-1:0] s1_imm_r;
  logic            s1_pred_r;

  // stage 2 (result) registers
  logic            s2_valid_r;
  logic            s2_taken_r;
  logic            s2_mispred_r;
  logic [XLEN-1:0] s2_target_r;
  logic [XLEN-1:0] s2_next_pc_r;

  logic [CNT_W-1:0] br_count_r;
  logic [CNT_W-1:0] mispred_count_r;

  // handshake / advance controls
  logic s2_adv_s;
  logic s1_adv_s;
  logic in_fire_s;
  logic out_fire_s;

  // stage 1 combinational results
  logic            taken_s;
  logic            mispred_s;
  logic [XLEN-1:0] target_s;
  logic [XLEN-1:0] seq_pc_s;
  logic [XLEN-1:0] next_pc_s;

  logic [CNT_W-1:0] br_cnt_nxt_s;
  logic [CNT_W-1:0] mis_cnt_nxt_s;

  // S2 can take a new entry when it is empty or its entry leaves this cycle;
  // S1 follows S2, so in_ready depends only on state and out_ready.
  assign out_fire_s = s2_valid_r & out_ready;
  assign s2_adv_s   = ~s2_valid_r | out_ready;
  assign s1_adv_s   = ~s1_valid_r | s2_adv_s;
  assign in_ready   = s1_adv_s;
  assign in_fire_s  = in_valid & s1_adv_s;

  assign out_valid     = s2_valid_r;
  assign br_taken      = s2_taken_r;
  assign mispredict    = s2_mispred_r;
  assign target        = s2_target_r;
  assign next_pc       = s2_next_pc_r;
  assign br_count      = br_count_r;
  assign mispred_count = mispred_count_r;

  // Evaluate the branch condition on the S1 operands.
  always_comb begin
    taken_s = 1'b0;
    case (s1_type_r)
      BR_EQ:   taken_s = (s1_a_r == s1_b_r);
      BR_NE:   taken_s = (s1_a_r != s1_b_r);
      BR_LTU:  taken_s = (s1_a_r <  s1_b_r);
      BR_GEU:  taken_s = (s1_a_r >= s1_b_r);
      BR_LT:   taken_s = ($signed(s1_a_r) <  $signed(s1_b_r));
      BR_GE:   taken_s = ($signed(s1_a_r) >= $signed(s1_b_r));
      BR_AL:   taken_s = 1'b1;
      BR_NV:   taken_s = 1'b0;
      default: taken_s = 1'b0;
    endcase
  end

  // Target and fall-through addresses wrap modulo 2^XLEN.
  always_comb begin
    target_s  = s1_pc_r + s1_imm_r;
    seq_pc_s  = s1_pc_r + PC_INC_V;
    mispred_s = taken_s ^ s1_pred_r;
    if (taken_s) begin
      next_pc_s = target_s;
    end else begin
      next_pc_s = seq_pc_s;
    end
  end

  // Saturating statistics update; clear wins over a same-cycle increment.
  always_comb begin
    br_cnt_nxt_s  = br_count_r;
    mis_cnt_nxt_s = mispred_count_r;
    if (cnt_clr) begin
      br_cnt_nxt_s  = CNT_ZERO;
      mis_cnt_nxt_s = CNT_ZERO;
    end else if (out_fire_s) begin
      if (br_count_r != CNT_MAX) begin
        br_cnt_nxt_s = br_count_r + CNT_ONE;
      end else begin
        br_cnt_nxt_s = br_count_r;
      end
      if (s2_mispred_r && (mispred_count_r != CNT_MAX)) begin
        mis_cnt_nxt_s = mispred_count_r + CNT_ONE;
      end else begin
        mis_cnt_nxt_s = mispred_count_r;
      end
    end else begin
      br_cnt_nxt_s  = br_count_r;
      mis_cnt_nxt_s = mispred_count_r;
    end
  end

  // S1 occupancy: flush kills it, otherwise it refills whenever it advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
    end else if (flush) begin
      s1_valid_r <= 1'b0;
    end else if (s1_adv_s) begin
      s1_valid_r <= in_valid;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // S1 request capture on an input handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a_r    <= XLEN_ZERO;
      s1_b_r    <= XLEN_ZERO;
      s1_type_r <= 3'b000;
      s1_pc_r   <= XLEN_ZERO;
      s1_imm_r  <= XLEN_ZERO;
      s1_pred_r <= 1'b0;
    end else if (in_fire_s) begin
      s1_a_r    <= a;
      s1_b_r    <= b;
      s1_type_r <= br_type;
      s1_pc_r   <= pc;
      s1_imm_r  <= imm;
      s1_pred_r <= pred_taken;
    end else begin
      s1_a_r    <= s1_a_r;
      s1_b_r    <= s1_b_r;
      s1_type_r <= s1_type_r;
      s1_pc_r   <= s1_pc_r;
      s1_imm_r  <= s1_imm_r;
      s1_pred_r <= s1_pred_r;
    end
  end

  // S2 occupancy: flush kills it, otherwise it takes S1 when it advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
    end else if (flush) begin
      s2_valid_r <= 1'b0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
    end else begin
      s2_valid_r <= s2_valid_r;
    end
  end

  // S2 result capture; held while the consumer back-pressures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_taken_r   <= 1'b0;
      s2_mispred_r <= 1'b0;
      s2_target_r  <= XLEN_ZERO;
      s2_next_pc_r <= XLEN_ZERO;
    end else if (s2_adv_s && s1_valid_r) begin
      s2_taken_r   <= taken_s;
      s2_mispred_r <= mispred_s;
      s2_target_r  <= target_s;
      s2_next_pc_r <= next_pc_s;
    end else begin
      s2_taken_r   <= s2_taken_r;
      s2_mispred_r <= s2_mispred_r;
      s2_target_r  <= s2_target_r;
      s2_next_pc_r <= s2_next_pc_r;
    end
  end

  // Statistics counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count_r      <= CNT_ZERO;
      mispred_count_r <= CNT_ZERO;
    end else begin
      br_count_r      <= br_cnt_nxt_s;
      mispred_count_r <= mis_cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: table-driven compare sweep, directed
// multi-cycle corner cases and randomized traffic against a transaction model.
module tb_branch_resolve_unit;

  localparam longint TWO32 = 64'sd4294967296;

  logic        clk = 1'b0;
  logic        rst_n, flush, cnt_clr, in_valid, out_ready, pred_taken;
  logic [2:0]  br_type;
  logic [31:0] a, b, pc, imm;

  logic        in_ready, out_valid, br_taken, mispredict;
  logic [31:0] target, next_pc;
  logic [15:0] br_count, mispred_count;

  logic        in_ready4, out_valid4, br_taken4, mispredict4;
  logic [31:0] target4, next_pc4;
  logic [3:0]  br_count4, mispred_count4;

  branch_resolve_unit #(.XLEN(32), .CNT_W(16), .PC_INC(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .br_type(br_type),
    .pc(pc), .imm(imm), .pred_taken(pred_taken), .out_valid(out_valid),
    .out_ready(out_ready), .br_taken(br_taken), .mispredict(mispredict),
    .target(target), .next_pc(next_pc), .br_count(br_count),
    .mispred_count(mispred_count)
  );

  branch_resolve_unit #(.XLEN(32), .CNT_W(4), .PC_INC(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ready(in_ready4), .a(a), .b(b), .br_type(br_type),
    .pc(pc), .imm(imm), .pred_taken(pred_taken), .out_valid(out_valid4),
    .out_ready(out_ready), .br_taken(br_taken4), .mispredict(mispredict4),
    .target(target4), .next_pc(next_pc4), .br_count(br_count4),
    .mispred_count(mispred_count4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        taken;
    logic        mis;
    logic [31:0] tgt;
    logic [31:0] npc;
    int          age;
  } res_t;

  typedef struct {
    logic [2:0]  t;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp;
  } vec_t;

  res_t q[$];
  vec_t tbl[16];
  int   m_br16, m_mis16, m_br4, m_mis4;
  bit   last_acc, last_fire;
  int   total, bad;
  int   sent, got, br_snap, mis_snap;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of one branch, from plain integer arithmetic.
  function automatic res_t model_calc(input logic [2:0] t, input logic [31:0] av,
                                      input logic [31:0] bv, input logic [31:0] pcv,
                                      input logic [31:0] immv, input logic pred);
    res_t   r;
    longint ua, ub, sa, sb;
    bit     tk;
    ua = longint'(av);
    ub = longint'(bv);
    sa = av[31] ? ua - TWO32 : ua;
    sb = bv[31] ? ub - TWO32 : ub;
    case (t)
      3'd0:    tk = (ua == ub);
      3'd1:    tk = (ua != ub);
      3'd2:    tk = (ua <  ub);
      3'd3:    tk = (ua >= ub);
      3'd4:    tk = (sa <  sb);
      3'd5:    tk = (sa >= sb);
      3'd6:    tk = 1'b1;
      default: tk = 1'b0;
    endcase
    r.taken = tk;
    r.mis   = (tk != pred);
    r.tgt   = 32'((longint'(pcv) + longint'(immv)) % TWO32);
    r.npc   = tk ? r.tgt : 32'((longint'(pcv) + 64'sd4) % TWO32);
    r.age   = 1;
    return r;
  endfunction

  function automatic int sat_inc(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_br16 = 0; m_mis16 = 0; m_br4 = 0; m_mis4 = 0;
    last_acc = 1'b0; last_fire = 1'b0;
  endtask

  task automatic check_outputs();
    bit ev;
    ev = (q.size() > 0) && (q[0].age >= 2);
    chk("in_ready",  in_ready,  (q.size() < 2) || out_ready);
    chk("in_ready4", in_ready4, (q.size() < 2) || out_ready);
    chk("out_valid",  out_valid,  ev);
    chk("out_valid4", out_valid4, ev);
    if (ev) begin
      chk("br_taken",   br_taken,   q[0].taken);
      chk("mispredict", mispredict, q[0].mis);
      chk("target",     target,     q[0].tgt);
      chk("next_pc",    next_pc,    q[0].npc);
      chk("next_pc4",   next_pc4,   q[0].npc);
    end
    chk("br_count",       br_count,       m_br16);
    chk("mispred_count",  mispred_count,  m_mis16);
    chk("br_count4",      br_count4,      m_br4);
    chk("mispred_count4", mispred_count4, m_mis4);
  endtask

  task automatic model_update();
    bit   ev, rdy, fire, acc;
    res_t r;
    ev   = (q.size() > 0) && (q[0].age >= 2);
    rdy  = (q.size() < 2) || out_ready;
    fire = ev && out_ready;
    acc  = in_valid && rdy;
    if (cnt_clr) begin
      m_br16 = 0; m_mis16 = 0; m_br4 = 0; m_mis4 = 0;
    end else if (fire) begin
      m_br16 = sat_inc(m_br16, 65535);
      m_br4  = sat_inc(m_br4, 15);
      if (q[0].mis) begin
        m_mis16 = sat_inc(m_mis16, 65535);
        m_mis4  = sat_inc(m_mis4, 15);
      end
    end
    if (fire) void'(q.pop_front());
    if (flush) begin
      q.delete();
    end else begin
      foreach (q[i]) q[i].age = q[i].age + 1;
      if (acc) begin
        r = model_calc(br_type, a, b, pc, imm, pred_taken);
        q.push_back(r);
      end
    end
    last_fire = fire;
    last_acc  = acc && !flush;
  endtask

  // One clock cycle: inputs were set just after the falling edge.
  task automatic tick();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_neg, exp_eq;
    total = 0; bad = 0;
    exp_neg = 8'b0101_1010;
    exp_eq  = 8'b0110_1001;
    for (int i = 0; i < 8; i++) begin
      tbl[i].t   = 3'(i);
      tbl[i].a   = 32'hFFFF_FFFF;
      tbl[i].b   = 32'h0000_0001;
      tbl[i].exp = exp_neg[i];
      tbl[i+8].t   = 3'(i);
      tbl[i+8].a   = 32'h1234_5678;
      tbl[i+8].b   = 32'h1234_5678;
      tbl[i+8].exp = exp_eq[i];
    end

    rst_n = 1'b0; idle(); pred_taken = 1'b0;
    br_type = 3'b000; a = 32'h0; b = 32'h0; pc = 32'h0; imm = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_br_taken", br_taken, 1'b0);
    chk("rst_mispredict", mispredict, 1'b0);
    chk("rst_target", target, 32'h0);
    chk("rst_next_pc", next_pc, 32'h0);
    chk("rst_br_count", br_count, 16'h0);
    chk("rst_mispred_count", mispred_count, 16'h0);

    // compare sweep: one request per cycle, results two cycles later
    for (int i = 0; i < 18; i++) begin
      in_valid = (i < 16);
      if (i < 16) begin
        br_type = tbl[i].t; a = tbl[i].a; b = tbl[i].b;
      end
      pc = 32'h0000_1000 + 32'(i * 4); imm = 32'h0000_0040; pred_taken = 1'b0;
      if (i >= 2) begin
        chk("sweep_valid", out_valid, 1'b1);
        chk("sweep_taken", br_taken, tbl[i-2].exp);
      end else begin
        chk("sweep_latency", out_valid, 1'b0);
      end
      tick();
    end
    idle(); repeat (2) tick();

    // target wrap
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    in_valid = 1'b1; br_type = 3'b110; pc = 32'hFFFF_FFFC; imm = 32'h0000_0008;
    pred_taken = 1'b0; a = 32'h0; b = 32'h0;
    tick(); in_valid = 1'b0; tick();
    chk("wrap_valid", out_valid, 1'b1);
    chk("wrap_target", target, 32'h0000_0004);
    chk("wrap_next_pc", next_pc, 32'h0000_0004);
    chk("wrap_mispredict", mispredict, 1'b1);
    tick();
    chk("wrap_mispred_count", mispred_count, 16'd1);

    // back-pressure: four requests, consumer stalls five cycles
    idle(); cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      out_ready = (cyc >= 5);
      in_valid = (sent < 4);
      br_type = (sent % 2 == 0) ? 3'b110 : 3'b111;
      pc = 32'h0000_0100 + 32'(sent * 16); imm = 32'h0000_0020; pred_taken = 1'b0;
      #1;
      if (cyc == 2) begin
        chk("bp_in_ready_low", in_ready, 1'b0);
        chk("bp_accepted", sent, 2);
      end
      if (cyc >= 2 && cyc <= 5) begin
        chk("bp_valid_hold", out_valid, 1'b1);
        chk("bp_stable_target", target, 32'h0000_0120);
        chk("bp_stable_taken", br_taken, 1'b1);
      end
      tick();
      if (last_acc) sent++;
      if (last_fire) got++;
    end
    chk("bp_delivered", got, 4);
    chk("bp_br_count", br_count, 16'd4);

    // flush with both stages full and a request offered
    idle(); out_ready = 1'b0; in_valid = 1'b1; br_type = 3'b110;
    pc = 32'h0000_0200; imm = 32'h0000_0004; tick();
    pc = 32'h0000_0204; tick();
    chk("fl_pre_valid", out_valid, 1'b1);
    br_snap = m_br16; mis_snap = m_mis16;
    flush = 1'b1; pc = 32'h0000_0208; tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("fl_no_out", out_valid, 1'b0);
      chk("fl_br_count", br_count, br_snap);
      chk("fl_mispred_count", mispred_count, mis_snap);
      tick();
    end

    // saturation on the 4-bit counters, then clear against a handshake
    idle(); cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    in_valid = 1'b1; br_type = 3'b110; pred_taken = 1'b0;
    for (int k = 0; k < 17; k++) begin
      pc = 32'h0000_0300 + 32'(k * 4); tick();
    end
    in_valid = 1'b0; repeat (3) tick();
    chk("sat_br4", br_count4, 4'd15);
    chk("sat_mis4", mispred_count4, 4'd15);
    chk("sat_br16", br_count, 16'd17);
    chk("sat_mis16", mispred_count, 16'd17);
    in_valid = 1'b1; pc = 32'h0000_0400; tick(); in_valid = 1'b0; tick();
    chk("clr_pre_valid", out_valid4, 1'b1);
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    chk("clr_br4", br_count4, 4'd0);
    chk("clr_mis4", mispred_count4, 4'd0);
    chk("clr_br16", br_count, 16'd0);
    chk("clr_mis16", mispred_count, 16'd0);

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      out_ready  = ($urandom_range(0, 9) < 7);
      flush      = ($urandom_range(0, 39) == 0);
      cnt_clr    = ($urandom_range(0, 39) == 0);
      br_type    = 3'($urandom_range(0, 7));
      a          = $urandom;
      b          = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 4) == 0) b = a ^ 32'h8000_0000;
      pc         = $urandom & 32'hFFFF_FFFC;
      imm        = $urandom;
      pred_taken = 1'($urandom_range(0, 1));
      tick();
    end
    idle(); repeat (3) tick();

    // asynchronous reset in the middle of a stream
    in_valid = 1'b1; br_type = 3'b110; pred_taken = 1'b0; imm = 32'h0000_0010;
    for (int k = 0; k < 4; k++) begin
      pc = 32'h0000_0500 + 32'(k * 4); tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 1'b0);
    chk("ar_br_taken", br_taken, 1'b0);
    chk("ar_mispredict", mispredict, 1'b0);
    chk("ar_target", target, 32'h0);
    chk("ar_next_pc", next_pc, 32'h0);
    chk("ar_br_count", br_count, 16'h0);
    chk("ar_mispred_count", mispred_count, 16'h0);
    chk("ar_out_valid4", out_valid4, 1'b0);
    chk("ar_br_count4", br_count4, 4'h0);
    in_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1'b1);
    chk("rel_out_valid", out_valid, 1'b0);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
